bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
- Sits directly upstream of the 4-digit multiplexed 7-segment display.
- Drives the display's four nibble inputs: thousands to Ain, hundreds to Bin, tens to Cin, ones to Din.
- Converts one binary value per start request. Output digits hold stable between conversions, so the display never shows partial results.

---
 rtl/bin_to_bcd_seq_if.sv | 25 ++
 rtl/bin_to_bcd_seq.sv | 106 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and digit bundle between a binary source, bin_to_bcd_seq and the
// 4-digit 7-segment display (thousands->Ain, hundreds->Bin, tens->Cin, ones->Din).
interface bin_to_bcd_seq_if #(
  parameter int unsigned IN_WIDTH = 14
);
  logic                start_i;
  logic [IN_WIDTH-1:0] bin_i;
  logic                busy_o;
  logic                done_o;
  logic                ovf_o;
  logic [3:0]          thousands_o;
  logic [3:0]          hundreds_o;
  logic [3:0]          tens_o;
  logic [3:0]          ones_o;

  modport master (
    output start_i, bin_i,
    input  busy_o, done_o, ovf_o, thousands_o, hundreds_o, tens_o, ones_o
  );

  modport slave (
    input  start_i, bin_i,
    output busy_o, done_o, ovf_o, thousands_o, hundreds_o, tens_o, ones_o
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Inputs above 9999 saturate to 9999 and raise ovf_o; digits only change on completion.
module bin_to_bcd_seq #(
  parameter int unsigned IN_WIDTH = 14
) (
  input logic             clk_50MHz_i,
  input logic             rst_sync_ha_i,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned         MAX_BCD = 9999;
  localparam int unsigned         CNT_W   = $clog2(IN_WIDTH + 1);
  localparam logic [IN_WIDTH-1:0] SAT_VAL = IN_WIDTH'(MAX_BCD);
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(IN_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] operand_q, operand_d;
  logic [15:0]         scratch_q, scratch_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [15:0]         digits_q, digits_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [15:0]         adj;
  logic                over_max;

  // Constant-false when IN_WIDTH < 14, so saturation folds away.
  always_comb over_max = 32'(bus.bin_i) > MAX_BCD;

  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    ovf_flag_d = ovf_flag_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          operand_d  = over_max ? SAT_VAL : bus.bin_i;
          ovf_flag_d = over_max;
          scratch_d  = '0;
          count_d    = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Operand MSB enters the scratch LSB; adj[15] is always 0 since scratch <= 9999.
        {scratch_d, operand_d} = {adj, operand_q} << 1;
        count_d                = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          digits_d = scratch_d;
          ovf_d    = ovf_flag_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) begin
      state_q    <= IDLE;
      operand_q  <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      ovf_flag_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      ovf_flag_q <= ovf_flag_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy_o      = (state_q == SHIFT);
  assign bus.done_o      = done_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.thousands_o = digits_q[15:12];
  assign bus.hundreds_o  = digits_q[11:8];
  assign bus.tens_o      = digits_q[7:4];
  assign bus.ones_o      = digits_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: results are packed as {ovf, th, hu, te, on}
// (17 bits) and compared with hand-written constants or a decimal reference.
module tb_bin_to_bcd_seq;
  localparam int unsigned IN_WIDTH = 14;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  bin_to_bcd_seq_if #(.IN_WIDTH(IN_WIDTH)) bus ();

  bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH)) dut (
    .clk_50MHz_i  (clk),
    .rst_sync_ha_i(rst),
    .bus          (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned obs_pack();
    return int'({bus.ovf_o, bus.thousands_o, bus.hundreds_o, bus.tens_o, bus.ones_o});
  endfunction

  // Decimal reference, independent of the shift-and-add algorithm.
  function automatic int unsigned ref_pack(input int unsigned v);
    int unsigned s, o;
    o = (v > 9999) ? 1 : 0;
    s = (v > 9999) ? 9999 : v;
    return (o << 16) | ((s / 1000) << 12) | (((s / 100) % 10) << 8) |
           (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done_o is seen; 40 means it never came.
  task automatic wait_done(output int unsigned lat);
    lat = 0;
    while (lat < 40 && !bus.done_o) begin
      tick();
      lat++;
    end
  endtask

  task automatic convert(input int unsigned v, input int unsigned exp, input bit full);
    int unsigned lat;
    bus.start_i = 1'b1;
    bus.bin_i   = IN_WIDTH'(v);
    tick();
    bus.start_i = 1'b0;
    bus.bin_i   = IN_WIDTH'($urandom);
    if (full) check_eq("busy_after_accept", int'(bus.busy_o), 1);
    wait_done(lat);
    check_eq("latency", lat, 14);
    check_eq($sformatf("result_%0d", v), obs_pack(), exp);
    if (full) begin
      check_eq("busy_in_done_cycle", int'(bus.busy_o), 0);
      tick();
      check_eq("done_width", int'(bus.done_o), 0);
      check_eq($sformatf("hold_%0d", v), obs_pack(), exp);
    end
  endtask

  initial begin
    int unsigned lat, n, prev;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.bin_i   = '0;
    repeat (3) tick();
    check_eq("rst_busy", int'(bus.busy_o), 0);
    check_eq("rst_done", int'(bus.done_o), 0);
    check_eq("rst_digits", obs_pack(), 0);
    rst = 1'b0;
    tick();

    convert(0,     17'h00000, 1'b1);
    convert(1234,  17'h01234, 1'b1);
    convert(9999,  17'h09999, 1'b1);
    convert(16383, 17'h19999, 1'b1);
    convert(10000, 17'h19999, 1'b1);
    convert(9998,  17'h09998, 1'b1);
    convert(507,   17'h00507, 1'b1);

    // Start during SHIFT must be ignored.
    bus.start_i = 1'b1;
    bus.bin_i   = IN_WIDTH'(4321);
    tick();
    bus.start_i = 1'b0;
    repeat (5) tick();
    bus.start_i = 1'b1;
    bus.bin_i   = IN_WIDTH'(7);
    tick();
    bus.start_i = 1'b0;
    wait_done(lat);
    check_eq("ignore_latency", lat, 8);
    check_eq("ignore_result", obs_pack(), 17'h04321);
    n = 0;
    repeat (20) begin
      tick();
      if (bus.done_o) n++;
    end
    check_eq("ignore_extra_done", n, 0);
    check_eq("ignore_idle", int'(bus.busy_o), 0);

    // Reset mid-conversion aborts with no done pulse.
    bus.start_i = 1'b1;
    bus.bin_i   = IN_WIDTH'(589);
    tick();
    bus.start_i = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", int'(bus.busy_o), 0);
    check_eq("abort_done", int'(bus.done_o), 0);
    check_eq("abort_digits", obs_pack(), 0);
    n = 0;
    repeat (20) begin
      tick();
      if (bus.done_o) n++;
    end
    check_eq("abort_no_done", n, 0);
    convert(42, 17'h00042, 1'b1);

    // Held start: one conversion per 15 cycles, each using its accept-edge value.
    bus.start_i = 1'b1;
    bus.bin_i   = '0;
    tick();
    prev = 0;
    for (int unsigned j = 0; j <= 20; j++) begin
      bus.bin_i = IN_WIDTH'($urandom);
      wait_done(lat);
      check_eq($sformatf("held_%0d", j), obs_pack(), ref_pack(j));
      if (j > 0) check_eq("held_period", cyc - prev, 15);
      prev = cyc;
      bus.bin_i = IN_WIDTH'(j + 1);
      if (j == 20) bus.start_i = 1'b0;
      tick();
    end
    check_eq("held_stop", int'(bus.busy_o), 0);

    // Sparse sweep across the full input range.
    for (int unsigned v = 0; v < 16384; v += 61) convert(v, ref_pack(v), 1'b0);
    convert(16383, ref_pack(16383), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
